// File: rtl/instruction_memory_banked.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_memory_banked
//  Purpose  : Multi-bank writable instruction store with a registered fetch
//             port, an edge-triggered bank-switch handshake and a valid/ready
//             loader port that can only target banks not currently executing.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   system clock, rising edge
//    reset          in   synchronous active-high reset
//    address        in   fetch address (ADDR_W)
//    programSelect  in   one-hot-ish bank request, lowest set bit wins
//    switchReq      in   switch request, acted upon on its rising edge
//    switchAck      out  one-cycle pulse in the cycle after SWITCH
//    activeProgram  out  index of the latched bank
//    noProgram      out  no bank latched
//    instruction    out  registered fetch data (1-cycle latency)
//    instrValid     out  fetch data belongs to a running bank
//    loadValid      in   loader presents a word
//    loadReady      out  word is accepted this cycle
//    loadBank       in   target bank of the load
//    loadAddr       in   target word of the load
//    loadData       in   word to write
//    parityError    out  sticky read-parity error (PARITY_CHECK_EN only)
//  Build option
//    PARITY_CHECK_EN : adds an even-parity bit per word and parityError.
//  Notes
//    NUM_PROGRAMS must be at least 2; DEPTH must be a power of two.
// ============================================================================
module instruction_memory_banked #(
   parameter int NUM_PROGRAMS = 8,
   parameter int DEPTH        = 128,
   parameter int INSTR_W      = 16,
   parameter int ADDR_W       = $clog2(DEPTH),
   parameter int BANK_W       = $clog2(NUM_PROGRAMS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       address,
   input  logic [NUM_PROGRAMS-1:0] programSelect,
   input  logic                    switchReq,
   output logic                    switchAck,
   output logic [BANK_W-1:0]       activeProgram,
   output logic                    noProgram,
   output logic [INSTR_W-1:0]      instruction,
   output logic                    instrValid,
   input  logic                    loadValid,
   output logic                    loadReady,
   input  logic [BANK_W-1:0]       loadBank,
   input  logic [ADDR_W-1:0]       loadAddr,
   input  logic [INSTR_W-1:0]      loadData
`ifdef PARITY_CHECK_EN
   ,
   output logic                    parityError
`endif
);

`ifdef PARITY_CHECK_EN
   localparam int MEM_W = INSTR_W + 1;
`else
   localparam int MEM_W = INSTR_W;
`endif
   localparam int WORDS = NUM_PROGRAMS * DEPTH;
   localparam int IDX_W = BANK_W + ADDR_W;
   localparam logic [BANK_W:0] C_NUM_BANKS = NUM_PROGRAMS[BANK_W:0];

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                w_switch_start;

   logic                r_req_q;
   logic                w_req_rise;

   logic [BANK_W-1:0]   r_active;
   logic                r_noprog;
   logic                r_ack;
   logic [INSTR_W-1:0]  r_instr;
   logic                r_valid;

   logic [BANK_W-1:0]   w_sel_idx;
   logic                w_sel_any;

   logic                w_bank_ok;
   logic                w_load_ready;
   logic                w_load_fire;
   logic [IDX_W-1:0]    w_wr_idx;
   logic [IDX_W-1:0]    w_rd_idx;
   logic [MEM_W-1:0]    w_wr_word;
   logic [MEM_W-1:0]    w_rd_word;

   // Contents start at zero and are never touched by reset, so a loaded
   // program survives a reset of the control logic.
   logic [MEM_W-1:0]    mem [WORDS] = '{default: '0};

   // ------------------------------------------------------------------------
   // Switch request edge detect
   // ------------------------------------------------------------------------
   assign w_req_rise = switchReq & ~r_req_q;

   // ------------------------------------------------------------------------
   // Priority encoder: scanning high-to-low so the lowest set bit is the
   // last assignment and therefore wins.
   // ------------------------------------------------------------------------
   always_comb begin
      w_sel_idx = '0;
      w_sel_any = 1'b0;
      for (int i = NUM_PROGRAMS - 1; i >= 0; i--) begin
         if (programSelect[i]) begin
            w_sel_idx = i[BANK_W-1:0];
            w_sel_any = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state   = r_state;
      w_switch_start = 1'b0;
      case (r_state)
         ST_IDLE, ST_RUN: begin
            if (w_req_rise) begin
               w_next_state   = ST_SWITCH;
               w_switch_start = 1'b1;
            end
         end
         ST_SWITCH: begin
            // r_noprog already holds the outcome latched on entry.
            w_next_state = r_noprog ? ST_IDLE : ST_RUN;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Bank latch, handshake and registered fetch
   // ------------------------------------------------------------------------
   assign w_rd_idx  = {r_active, address};
   assign w_rd_word = mem[w_rd_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_req_q  <= 1'b0;
         r_active <= '0;
         r_noprog <= 1'b1;
         r_ack    <= 1'b0;
         r_instr  <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_req_q <= switchReq;
         r_ack   <= (r_state == ST_SWITCH);
         r_valid <= (r_state == ST_RUN);
         if (w_switch_start) begin
            // An empty selection keeps the previous index but marks no bank.
            if (w_sel_any) begin
               r_active <= w_sel_idx;
            end
            r_noprog <= ~w_sel_any;
         end
         r_instr <= r_noprog ? '0 : w_rd_word[INSTR_W-1:0];
      end
   end

   // ------------------------------------------------------------------------
   // Load port. Uses the pre-switch bank index, so a load coinciding with a
   // switch request is judged against the bank that is running now.
   // ------------------------------------------------------------------------
   assign w_bank_ok    = ({1'b0, loadBank} < C_NUM_BANKS);
   assign w_load_ready = ~reset & (r_state != ST_SWITCH) & w_bank_ok &
                         (r_noprog | (loadBank != r_active));
   assign w_load_fire  = loadValid & w_load_ready;
   assign w_wr_idx     = {loadBank, loadAddr};

`ifdef PARITY_CHECK_EN
   assign w_wr_word = {^loadData, loadData};
`else
   assign w_wr_word = loadData;
`endif

   // Read-before-write falls out of the registered read sampling the array
   // before the non-blocking write lands.
   always_ff @(posedge clk) begin
      if (w_load_fire) begin
         mem[w_wr_idx] <= w_wr_word;
      end
   end

`ifdef PARITY_CHECK_EN
   // ------------------------------------------------------------------------
   // Parity check on the registered output word
   // ------------------------------------------------------------------------
   logic r_par;
   logic r_perr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_par  <= 1'b0;
         r_perr <= 1'b0;
      end else begin
         r_par  <= r_noprog ? 1'b0 : w_rd_word[INSTR_W];
         r_perr <= r_perr | (r_valid & (^{r_instr, r_par}));
      end
   end

   assign parityError = r_perr;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign switchAck     = r_ack;
   assign activeProgram = r_active;
   assign noProgram     = r_noprog;
   assign instruction   = r_instr;
   assign instrValid    = r_valid;
   assign loadReady     = w_load_ready;

endmodule

`default_nettype wire

// File: tb/tb_instruction_memory_banked.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_memory_banked
//  Purpose  : Self-checking bench for instruction_memory_banked: table-driven
//             loads, scoreboard-checked fetches and hand-written switch,
//             hold, empty-select and reset-mid-switch sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_memory_banked;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  address;
   logic [7:0]  programSelect;
   logic        switchReq;
   logic        switchAck;
   logic [2:0]  activeProgram;
   logic        noProgram;
   logic [15:0] instruction;
   logic        instrValid;
   logic        loadValid;
   logic        loadReady;
   logic [2:0]  loadBank;
   logic [6:0]  loadAddr;
   logic [15:0] loadData;
`ifdef PARITY_CHECK_EN
   logic        parityError;
`endif

   instruction_memory_banked dut (
      .clk           (clk),
      .reset         (reset),
      .address       (address),
      .programSelect (programSelect),
      .switchReq     (switchReq),
      .switchAck     (switchAck),
      .activeProgram (activeProgram),
      .noProgram     (noProgram),
      .instruction   (instruction),
      .instrValid    (instrValid),
      .loadValid     (loadValid),
      .loadReady     (loadReady),
      .loadBank      (loadBank),
      .loadAddr      (loadAddr),
      .loadData      (loadData)
`ifdef PARITY_CHECK_EN
      ,
      .parityError   (parityError)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  bank;
      logic [6:0]  addr;
      logic [15:0] data;
      logic        exp_ready;
   } load_vec_t;

   typedef struct {
      logic [6:0]  addr;
      logic [15:0] exp_instr;
   } fetch_vec_t;

   typedef struct {
      logic [15:0] instr;
      logic        valid;
   } sb_t;

   int  total = 0;
   int  bad   = 0;
   sb_t sb_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input load_vec_t v);
      loadBank  = v.bank;
      loadAddr  = v.addr;
      loadData  = v.data;
      loadValid = 1'b1;
      #1;
      chk("loadReady", {31'd0, loadReady}, {31'd0, v.exp_ready});
      tick();
      loadValid = 1'b0;
   endtask

   // Drive the address, push the expectation, pop and compare when the
   // registered output appears one cycle later.
   task automatic fetch(input logic [6:0] a, input logic [15:0] e, input logic ev);
      sb_t exp_item;
      sb_t got_item;
      address = a;
      exp_item.instr = e;
      exp_item.valid = ev;
      sb_q.push_back(exp_item);
      tick();
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
         got_item = sb_q.pop_front();
         chk("instruction", {16'd0, instruction}, {16'd0, got_item.instr});
         chk("instrValid", {31'd0, instrValid}, {31'd0, got_item.valid});
      end
   endtask

   task automatic do_switch(input logic [7:0] sel, input logic [2:0] exp_act, input logic exp_noprog);
      programSelect = sel;
      switchReq     = 1'b1;
      tick();                                   // now in SWITCH
      chk("ack_in_switch", {31'd0, switchAck}, 32'd0);
      chk("activeProgram", {29'd0, activeProgram}, {29'd0, exp_act});
      chk("noProgram", {31'd0, noProgram}, {31'd0, exp_noprog});
      chk("loadReady_in_switch", {31'd0, loadReady}, 32'd0);
      switchReq = 1'b0;
      tick();                                   // cycle after SWITCH
      chk("switchAck", {31'd0, switchAck}, 32'd1);
      chk("valid_after_switch", {31'd0, instrValid}, 32'd0);
      tick();
      chk("ack_drop", {31'd0, switchAck}, 32'd0);
      chk("valid_settled", {31'd0, instrValid}, {31'd0, ~exp_noprog});
   endtask

   load_vec_t  lv[6];
   fetch_vec_t fv[5];

   initial begin
      int acks;

      lv[0] = '{bank: 3'd2, addr: 7'd0, data: 16'h0201, exp_ready: 1'b1};
      lv[1] = '{bank: 3'd2, addr: 7'd1, data: 16'h4332, exp_ready: 1'b1};
      lv[2] = '{bank: 3'd2, addr: 7'd2, data: 16'hE000, exp_ready: 1'b1};
      lv[3] = '{bank: 3'd5, addr: 7'd0, data: 16'h5A5A, exp_ready: 1'b1};
      lv[4] = '{bank: 3'd5, addr: 7'd3, data: 16'h1234, exp_ready: 1'b1};
      lv[5] = '{bank: 3'd3, addr: 7'd7, data: 16'hBEEF, exp_ready: 1'b1};

      fv[0] = '{addr: 7'd1,   exp_instr: 16'h4332};
      fv[1] = '{addr: 7'd0,   exp_instr: 16'h0201};
      fv[2] = '{addr: 7'd2,   exp_instr: 16'hE000};
      fv[3] = '{addr: 7'd3,   exp_instr: 16'h0000};
      fv[4] = '{addr: 7'd127, exp_instr: 16'h0000};

      reset         = 1'b1;
      address       = '0;
      programSelect = '0;
      switchReq     = 1'b0;
      loadValid     = 1'b0;
      loadBank      = '0;
      loadAddr      = '0;
      loadData      = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_instruction", {16'd0, instruction}, 32'd0);
      chk("rst_instrValid", {31'd0, instrValid}, 32'd0);
      chk("rst_noProgram", {31'd0, noProgram}, 32'd1);
      chk("rst_activeProgram", {29'd0, activeProgram}, 32'd0);
      chk("rst_switchAck", {31'd0, switchAck}, 32'd0);
      chk("rst_loadReady", {31'd0, loadReady}, 32'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_loadReady", {31'd0, loadReady}, 32'd1);

      // Table-driven loads while no bank is latched
      for (int i = 0; i < 6; i++) do_load(lv[i]);

      // Switch to bank 2 and read back via the scoreboard
      do_switch(8'b0000_0100, 3'd2, 1'b0);
      for (int i = 0; i < 5; i++) fetch(fv[i].addr, fv[i].exp_instr, 1'b1);

      // Selection changes outside a switch are ignored
      programSelect = 8'b0000_0001;
      tick();
      chk("sel_ignored", {29'd0, activeProgram}, 32'd2);

      // Loads into the running bank are refused; others are accepted
      do_load('{bank: 3'd2, addr: 7'd1, data: 16'hFFFF, exp_ready: 1'b0});
      fetch(7'd1, 16'h4332, 1'b1);
      do_load('{bank: 3'd3, addr: 7'd0, data: 16'h3333, exp_ready: 1'b1});

      // Lowest set bit wins; holding switchReq gives a single ack
      programSelect = 8'b1010_0000;
      switchReq     = 1'b1;
      acks          = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 5) switchReq = 1'b0;
         tick();
         acks += int'(switchAck);
      end
      chk("hold_ack_count", acks, 32'd1);
      chk("lowest_bit_bank", {29'd0, activeProgram}, 32'd5);
      fetch(7'd0, 16'h5A5A, 1'b1);
      fetch(7'd3, 16'h1234, 1'b1);

      // Empty selection: no bank, bank index held, ack still pulses
      do_switch(8'b0000_0000, 3'd5, 1'b1);
      fetch(7'd0, 16'h0000, 1'b0);
      fetch(7'd3, 16'h0000, 1'b0);
      do_load('{bank: 3'd5, addr: 7'd10, data: 16'h0A0A, exp_ready: 1'b1});

      // Bank 3 holds both the table load and the one taken while bank 2 ran
      do_switch(8'b0000_1000, 3'd3, 1'b0);
      fetch(7'd0, 16'h3333, 1'b1);
      fetch(7'd7, 16'hBEEF, 1'b1);

      // Reset during the SWITCH cycle
      programSelect = 8'b0000_0100;
      switchReq     = 1'b1;
      tick();
      reset     = 1'b1;
      switchReq = 1'b0;
      tick();
      chk("rsw_noProgram", {31'd0, noProgram}, 32'd1);
      chk("rsw_activeProgram", {29'd0, activeProgram}, 32'd0);
      chk("rsw_switchAck", {31'd0, switchAck}, 32'd0);
      chk("rsw_instrValid", {31'd0, instrValid}, 32'd0);
      reset = 1'b0;
      tick();
      chk("rsw_no_late_ack", {31'd0, switchAck}, 32'd0);
      chk("rsw_noProgram2", {31'd0, noProgram}, 32'd1);

      // Memory survives reset
      do_switch(8'b0000_0100, 3'd2, 1'b0);
      fetch(7'd0, 16'h0201, 1'b1);
      fetch(7'd1, 16'h4332, 1'b1);
      fetch(7'd2, 16'hE000, 1'b1);

      // Load taken while no bank ran is present in bank 5
      do_switch(8'b0010_0000, 3'd5, 1'b0);
      fetch(7'd10, 16'h0A0A, 1'b1);

`ifdef PARITY_CHECK_EN
      chk("parityError", {31'd0, parityError}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instruction_memory_banked.md
Name: instruction_memory_banked

Overview:
Parametrised successor to the fixed four-program instruction store. It holds NUM_PROGRAMS writable program banks of DEPTH words each, with a registered read port feeding the fetch stage. A handshake-controlled bank switch latches a priority-encoded program selection, and a valid/ready load port lets a loader fill any bank that is not currently executing.

Parameters:
NUM_PROGRAMS, 8, number of program banks; also the programSelect width
DEPTH, 128, words per bank; must be a power of two
INSTR_W, 16, instruction width in bits
ADDR_W, $clog2(DEPTH), fetch and load address width
BANK_W, $clog2(NUM_PROGRAMS), bank index width

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
address  input  ADDR_W  fetch address from the PC
programSelect  input  NUM_PROGRAMS  one bit per bank; lowest set bit wins
switchReq  input  1  request to re-latch programSelect; acts on the rising edge only
switchAck  output  1  one-cycle pulse when the new bank is active
activeProgram  output  BANK_W  index of the latched bank
noProgram  output  1  high when no bank is latched
instruction  output  INSTR_W  registered fetch data
instrValid  output  1  instruction is valid for the current bank
loadValid  input  1  loader presents a word
loadReady  output  1  the word will be accepted this cycle
loadBank  input  BANK_W  target bank of the load
loadAddr  input  ADDR_W  target word of the load
loadData  input  INSTR_W  word to write

Behaviour:
- Reset values: instruction=0, instrValid=0, activeProgram=0, noProgram=1, switchAck=0, loadReady=0, FSM=IDLE, switchReq edge register=0.
- Reset does not clear memory. Memory is initialised to 0 at elaboration.
- FSM states: IDLE (no bank latched), RUN, SWITCH.
  - IDLE/RUN -> SWITCH on a rising edge of switchReq (switchReq=1 and the previous-cycle sample=0).
  - SWITCH lasts exactly one cycle, then goes to RUN if a bank was latched, else IDLE.
- Entering SWITCH:
  - Latches the lowest set bit of programSelect into activeProgram and clears noProgram.
  - If programSelect=0: noProgram=1 and activeProgram is held.
- switchAck pulses in the cycle after SWITCH, regardless of outcome.
- Holding switchReq high does not re-trigger a switch.
- Changes on programSelect outside a switch are ignored.
- Fetch:
  - Every cycle, instruction <= mem[activeProgram][address]. Latency is 1 cycle.
  - instrValid <= (FSM==RUN). It is low during SWITCH and IDLE, and low on the first cycle after SWITCH.
  - When noProgram=1, instruction <= 0.
- Address wrap: address is ADDR_W bits, so no out-of-range access exists.
- Load port:
  - loadReady=1 when reset=0, FSM!=SWITCH, and (noProgram=1 or loadBank!=activeProgram).
  - A write occurs when loadValid && loadReady.
  - Rejected loads produce no write, and the loader must hold the word.
- Loads and the switch in the same cycle: the load is evaluated against the pre-switch activeProgram.
- Read/write to the same location in the same cycle returns the old data (read-before-write). This is only reachable when noProgram=1.
- Reset mid-load or mid-switch: any in-flight write is discarded, the FSM goes to IDLE, and memory already written is kept.

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - Each word stores an extra even-parity bit computed from loadData on write.
  - Read parity is checked on the registered output, and a sticky output parityError (1 bit, reset 0) sets when instrValid=1 and parity mismatches.
  - parityError clears only on reset.
- Undefined: no parity storage and no parityError port.

Test Plan:
- Reset, then check outputs: instruction=0, instrValid=0, noProgram=1, loadReady=1 the cycle after reset drops.
- Load bank 2 addr 0..2 with 0x0201, 0x4332, 0xE000. Then set programSelect=8'b0000_0100 and pulse switchReq. Expect switchAck 2 cycles after the edge and activeProgram=2. With address=1, expect instruction=0x4332 one cycle later with instrValid=1.
- Set programSelect=8'b1010_0000, then switch. Expect activeProgram=5 (lowest set bit). Holding switchReq high for 5 cycles gives exactly one switchAck.
- With bank 2 active: loadBank=2 gives loadReady=0 and memory unchanged on readback; loadBank=3 is accepted in 1 cycle.
- Set programSelect=0, then switch. Expect noProgram=1, instrValid=0, instruction=0, and switchAck still pulses.
- Assert reset mid-switch (cycle of SWITCH). Expect FSM IDLE, noProgram=1, no switchAck, and previously loaded bank 2 contents intact after re-selecting.
